// File: rtl/shift_rotate_pipe.sv
// Pipelined barrel shifter/rotator: stage k applies a 2^k step when shamt bit k is set.
// Elastic valid/ready chain with back-pressure; the last stage doubles as the output register.
module shift_rotate_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero
);

  // One power-of-two step; returns {carry, data}. Carry tracks the last bit pushed out.
  function automatic logic [WIDTH:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       mode,
    input logic             en,
    input logic             cin,
    input int               sh
  );
    logic [WIDTH-1:0] res;
    logic             cout;
    logic [SHW-1:0]   lo_idx;
    logic [SHW-1:0]   hi_idx;
    lo_idx = SHW'(sh - 1);
    hi_idx = SHW'(WIDTH - sh);
    res    = d;
    cout   = cin;
    if (en) begin
      case (mode)
        3'b000: begin res = d >> sh;            cout = d[lo_idx]; end
        3'b001: begin res = d << sh;            cout = d[hi_idx]; end
        3'b010: begin res = $signed(d) >>> sh;  cout = d[lo_idx]; end
        3'b011: res = (d >> sh) | (d << (WIDTH - sh));
        3'b100: res = (d << sh) | (d >> (WIDTH - sh));
        default: ;
      endcase
    end
    return {cout, res};
  endfunction

  logic [SHW:0]   w_ready;
  logic [SHW-1:0] w_valid;

  assign w_ready[SHW] = out_ready;
  assign in_ready     = w_ready[0] && !flush;

  for (genvar gi = 0; gi < SHW; gi++) begin : g_ready
    assign w_ready[gi] = !w_valid[gi] || w_ready[gi+1];
  end

  // Inner stages carry only the shamt bits still to be consumed, so each register narrows by one.
  for (genvar gi = 0; gi < SHW - 1; gi++) begin : g_stage
    logic [WIDTH-1:0]  w_din;
    logic [SHW-gi-1:0] w_sh;
    logic [2:0]        w_mode;
    logic              w_cin;
    logic              w_vin;
    logic [WIDTH:0]    w_step;
    logic [WIDTH-1:0]  r_data;
    logic [SHW-gi-2:0] r_shamt;
    logic [2:0]        r_mode;
    logic              r_carry;
    logic              r_valid;

    if (gi == 0) begin : g_src
      assign w_din  = in_data;
      assign w_sh   = in_shamt;
      assign w_mode = in_mode;
      assign w_cin  = 1'b0;
      assign w_vin  = in_valid;
    end else begin : g_src
      assign w_din  = g_stage[gi-1].r_data;
      assign w_sh   = g_stage[gi-1].r_shamt;
      assign w_mode = g_stage[gi-1].r_mode;
      assign w_cin  = g_stage[gi-1].r_carry;
      assign w_vin  = g_stage[gi-1].r_valid;
    end

    assign w_step      = shift_step(w_din, w_mode, w_sh[0], w_cin, 1 << gi);
    assign w_valid[gi] = r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_shamt <= '0;
        r_mode  <= '0;
        r_carry <= 1'b0;
      end else if (flush) begin
        r_valid <= 1'b0;
      end else if (w_ready[gi]) begin
        r_valid <= w_vin;
        r_data  <= w_step[WIDTH-1:0];
        r_carry <= w_step[WIDTH];
        r_mode  <= w_mode;
        r_shamt <= w_sh[SHW-gi-1:1];
      end
    end
  end

  logic [WIDTH:0]   w_last_step;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_carry;
  logic             r_out_zero;

  assign w_last_step = shift_step(g_stage[SHW-2].r_data, g_stage[SHW-2].r_mode,
                                  g_stage[SHW-2].r_shamt[0], g_stage[SHW-2].r_carry,
                                  1 << (SHW - 1));
  assign w_valid[SHW-1] = r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_carry <= 1'b0;
      r_out_zero  <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_ready[SHW-1]) begin
      r_out_valid <= g_stage[SHW-2].r_valid;
      r_out_data  <= w_last_step[WIDTH-1:0];
      r_out_carry <= w_last_step[WIDTH];
      r_out_zero  <= (w_last_step[WIDTH-1:0] == '0);
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_carry = r_out_carry;
  assign out_zero  = r_out_zero;

endmodule

// File: doc/shift_rotate_pipe.md
Name: shift_rotate_pipe

Overview:
- Parametrised, pipelined barrel shifter/rotator; the next generation of the team's single-mode 4-bit shift-right register chain.
- Adds configurable width, five shift/rotate modes, a per-transaction shift amount, and valid/ready flow control with back-pressure.
- Sits between a producer (e.g. the datapath ALU operand bus) and a consumer that may stall. Throughput is one result per clock.

Parameters:
- WIDTH, 8, data width; power of two, at least 4.
- SHW, $clog2(WIDTH), derived localparam: shift-amount width and pipeline depth (number of stages).

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- flush, input, 1: synchronous clear of all in-flight transactions.
- in_valid, input, 1: producer offers a transaction.
- in_ready, output, 1: block accepts the transaction this cycle.
- in_data, input, WIDTH: operand.
- in_shamt, input, SHW: shift/rotate amount, 0..WIDTH-1.
- in_mode, input, 3: 000 SRL, 001 SLL, 010 SRA, 011 ROR, 100 ROL, 101-111 pass-through.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer takes the result this cycle.
- out_data, output, WIDTH: result.
- out_carry, output, 1: last bit shifted out.
- out_zero, output, 1: out_data == 0.

Behaviour:
- Reset: rst_n low asynchronously clears every stage valid bit, data, sideband and flag. out_valid=0, out_data=0, out_carry=0, out_zero=0. in_ready=1 once rst_n is high and flush=0.
- Pipeline: SHW register stages.
  - Stage k conditionally shifts/rotates by 2^k according to shamt bit k.
  - Each stage carries mode, remaining shamt, carry and valid as sideband. The last stage is the output register.
- Accept: a transaction is accepted on a rising edge with in_valid && in_ready.
- Latency: the result is on out_data, with out_valid=1, after the SHW-th rising edge, counting the accepting edge as the first. For WIDTH=8 this is 3 edges.
- Elastic handshake:
  - ready_SHW = out_ready; ready_k = !valid_k || ready_(k+1); in_ready = ready_0 && !flush.
  - A stage loads from upstream when its own ready is high. When its own ready is low it holds.
  - No bubbles: with out_ready held high, one transaction is accepted and one retired per cycle.
- Stall: while out_valid && !out_ready, out_data, out_carry and out_zero are held stable. Upstream stages fill and then in_ready drops.
- SRL/SLL: vacated bits are filled with 0.
- SRA: vacated bits are filled with in_data[WIDTH-1].
- ROR/ROL: no bits are lost.
- out_carry:
  - SRL/SRA: in_data[shamt-1].
  - SLL: in_data[WIDTH-shamt].
  - shamt==0, rotates and pass-through: 0.
- Pass-through modes: in_data is output unchanged, shamt is ignored, carry=0.
- out_zero is computed from the final result and registered with it.
- flush=1 at a rising edge:
  - All valid bits clear. out_valid=0 after that edge.
  - Any in_valid presented that cycle is not accepted (in_ready=0).
  - Data registers may keep stale values; only valid bits matter.
- flush and out_ready high together: the flush wins and the result is discarded.
- Reset mid-stream: all in-flight data is lost, with no partial output.
- An in_shamt outside the range cannot occur by construction, because it is SHW bits wide.

Test Plan (WIDTH=8):
- Reset and single transactions, out_ready=1, one transaction at a time:
  - After reset: out_valid=0, in_ready=1.
  - SRL 0xB4 by 3 -> 0x16, carry=1, zero=0, out_valid 3 edges after accept.
  - SRA 0xB4 by 3 -> 0xF6, carry=1.
  - SLL 0x0F by 7 -> 0x80, carry=1.
  - ROL 0x81 by 1 -> 0x03, carry=0.
  - ROR 0x81 by 1 -> 0xC0, carry=0.
- Boundaries:
  - SRL 0x01 by 1 -> 0x00, zero=1, carry=1.
  - SLL 0xA5 by 0 -> 0xA5, carry=0.
  - Mode 110 with 0x5A, shamt 5 -> 0x5A.
- Streaming: 8 back-to-back transactions with out_ready=1 -> in_ready stays 1 and 8 results appear in order on 8 consecutive cycles.
- Back-pressure: hold out_ready=0 after the first result -> in_ready falls after 3 transactions are buffered and out_data stays constant. Raise out_ready -> all results drain in order, none lost or duplicated.
- Flush: with 3 transactions in flight, pulse flush together with in_valid -> no out_valid for those transactions, the concurrent input is not accepted, and the next transaction completes normally.
- Async reset: assert rst_n low between clock edges mid-stream -> out_valid and flags go to 0 immediately. After release, a new SRL 0xF0 by 4 -> 0x0F.
